mfb_frame_lng_gen: RTL and testbench

Single-region MFB frame generator; the transmit-side counterpart of the MFB frame length meter. It accepts a stream of frame lengths in items and emits MFB frames of exactly those lengths, filled with a deterministic per-frame counting pattern. It is used as a traffic source in front of MFB length-checking logic and in loopback tests, where the meter output must equal the length fed in.

---
 rtl/mfb_frame_lng_gen.sv | 198 +++++++++++++++++++
 tb/tb_mfb_frame_lng_gen.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfb_frame_lng_gen.sv
// Single-region MFB traffic source: turns a stream of frame lengths into MFB
// frames of exactly those lengths, payload = per-frame counting pattern.
module mfb_frame_lng_gen #(
    parameter int REGIONS     = 1,
    parameter int REGION_SIZE = 4,
    parameter int BLOCK_SIZE  = 8,
    parameter int ITEM_WIDTH  = 8,
    parameter int LNG_WIDTH   = 9
) (
    input  logic                                         CLK,
    input  logic                                         RESET_N,
    input  logic [LNG_WIDTH-1:0]                         LNG_DATA,
    input  logic                                         LNG_SRC_RDY,
    output logic                                         LNG_DST_RDY,
    output logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0] TX_DATA,
    output logic [$clog2(REGION_SIZE)-1:0]               TX_SOF_POS,
    output logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]    TX_EOF_POS,
    output logic                                         TX_SOF,
    output logic                                         TX_EOF,
    output logic                                         TX_SRC_RDY,
    input  logic                                         TX_DST_RDY
);

    localparam int W   = REGION_SIZE * BLOCK_SIZE;
    localparam int SPW = $clog2(REGION_SIZE);
    localparam int EPW = $clog2(W);
    localparam int BSW = $clog2(BLOCK_SIZE);
    localparam int NBW = SPW + 1;
    localparam int AW  = ((LNG_WIDTH > EPW + 1) ? LNG_WIDTH : EPW + 1) + 1;
    localparam logic [AW-1:0] W_A   = AW'(W);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    if (REGIONS != 1) begin : g_regions_check
        $error("mfb_frame_lng_gen supports REGIONS=1 only");
    end

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                  state_q, state_d;
    logic [LNG_WIDTH-1:0]    rem_q, rem_d;
    logic [NBW-1:0]          nb_q, nb_d;
    logic [ITEM_WIDTH-1:0]   val_q, val_d;
    logic [ITEM_WIDTH-1:0]   seq_q, seq_d;
    logic                    pend_vld_q;
    logic [LNG_WIDTH-1:0]    pend_lng_q;
    logic                    lng_en_q;

    logic [W*ITEM_WIDTH-1:0] tx_data_q;
    logic [SPW-1:0]          tx_sof_pos_q, sof_pos_d;
    logic [EPW-1:0]          tx_eof_pos_q, eof_pos_d;
    logic                    tx_sof_q, sof_d;
    logic                    tx_eof_q, eof_d;
    logic                    tx_src_rdy_q, vld_d;

    logic                    step;
    logic                    consume;
    logic                    consume_fire;
    logic [AW-1:0]           n1;
    logic                    start2;
    logic [AW-1:0]           sp;
    logic [AW-1:0]           e2;
    logic [NBW-1:0]          nb_eff;
    logic [AW-1:0]           free_a;
    logic [AW-1:0]           rem_a;
    logic [AW-1:0]           lng_a;
    wire  [W*ITEM_WIDTH-1:0] tx_data_d;

    assign step         = !tx_src_rdy_q || TX_DST_RDY;
    assign consume_fire = step && consume;
    assign LNG_DST_RDY  = lng_en_q && (!pend_vld_q || consume_fire);

    // n1 items of the continuing frame sit at the bottom of the word; a new
    // frame (if any) occupies [sp, e2) above them.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        nb_d      = nb_q;
        val_d     = val_q;
        seq_d     = seq_q;
        consume   = 1'b0;
        n1        = '0;
        start2    = 1'b0;
        sp        = '0;
        e2        = '0;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        sof_pos_d = '0;
        eof_pos_d = '0;
        nb_eff    = nb_q;
        rem_a     = AW'(rem_q);
        lng_a     = AW'(pend_lng_q);

        if (state_q == ST_BUSY) begin
            if (rem_a <= W_A) begin
                n1        = rem_a;
                eof_d     = 1'b1;
                eof_pos_d = EPW'(rem_a - ONE_A);
                nb_eff    = NBW'(((rem_a - ONE_A) >> BSW) + ONE_A);
                nb_d      = nb_eff;
                state_d   = ST_IDLE;
            end else begin
                n1    = W_A;
                rem_d = LNG_WIDTH'(rem_a - W_A);
                val_d = val_q + ITEM_WIDTH'(W);
            end
        end

        free_a = W_A - (AW'(nb_eff) << BSW);

        if (state_d == ST_IDLE && pend_vld_q) begin
            if (lng_a == '0) begin
                consume = 1'b1;
            end else if (nb_eff < NBW'(REGION_SIZE) && lng_a > free_a) begin
                // Frame cannot end in this word, so one SOF/EOF per word holds.
                consume   = 1'b1;
                sof_d     = 1'b1;
                sof_pos_d = SPW'(nb_eff);
                start2    = 1'b1;
                sp        = W_A - free_a;
                e2        = W_A;
                rem_d     = LNG_WIDTH'(lng_a - free_a);
                val_d     = seq_q + ITEM_WIDTH'(free_a);
                seq_d     = seq_q + ITEM_WIDTH'(1);
                state_d   = ST_BUSY;
            end else if (nb_eff == '0) begin
                consume   = 1'b1;
                sof_d     = 1'b1;
                eof_d     = 1'b1;
                eof_pos_d = EPW'(lng_a - ONE_A);
                start2    = 1'b1;
                e2        = lng_a;
                nb_d      = NBW'(((lng_a - ONE_A) >> BSW) + ONE_A);
                seq_d     = seq_q + ITEM_WIDTH'(1);
            end else begin
                nb_d = '0;
            end
        end

        vld_d = (state_q == ST_BUSY) || start2;
    end

    genvar gi;
    for (gi = 0; gi < W; gi++) begin : g_item
        localparam logic [AW-1:0] K_A = AW'(gi);
        assign tx_data_d[gi*ITEM_WIDTH +: ITEM_WIDTH] =
            (K_A < n1) ? val_q + ITEM_WIDTH'(gi) :
            (start2 && K_A >= sp && K_A < e2) ? seq_q + ITEM_WIDTH'(K_A - sp) :
            '0;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            nb_q         <= '0;
            val_q        <= '0;
            seq_q        <= '0;
            pend_vld_q   <= 1'b0;
            pend_lng_q   <= '0;
            lng_en_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_sof_pos_q <= '0;
            tx_eof_pos_q <= '0;
            tx_sof_q     <= 1'b0;
            tx_eof_q     <= 1'b0;
            tx_src_rdy_q <= 1'b0;
        end else begin
            lng_en_q <= 1'b1;
            if (LNG_SRC_RDY && LNG_DST_RDY) begin
                pend_vld_q <= 1'b1;
                pend_lng_q <= LNG_DATA;
            end else if (consume_fire) begin
                pend_vld_q <= 1'b0;
            end
            if (step) begin
                state_q      <= state_d;
                rem_q        <= rem_d;
                nb_q         <= nb_d;
                val_q        <= val_d;
                seq_q        <= seq_d;
                tx_data_q    <= tx_data_d;
                tx_sof_pos_q <= sof_pos_d;
                tx_eof_pos_q <= eof_pos_d;
                tx_sof_q     <= sof_d;
                tx_eof_q     <= eof_d;
                tx_src_rdy_q <= vld_d;
            end
        end
    end

    assign TX_DATA    = tx_data_q;
    assign TX_SOF_POS = tx_sof_pos_q;
    assign TX_EOF_POS = tx_eof_pos_q;
    assign TX_SOF     = tx_sof_q;
    assign TX_EOF     = tx_eof_q;
    assign TX_SRC_RDY = tx_src_rdy_q;

endmodule

// File: tb/tb_mfb_frame_lng_gen.sv
// Bench for mfb_frame_lng_gen: directed word tables, mid-frame reset and a
// back-pressured random run checked by a frame length meter model.
module tb_mfb_frame_lng_gen;

    localparam int W  = 32;
    localparam int IW = 8;
    localparam int BS = 8;

    logic         CLK = 1'b0;
    logic         RESET_N = 1'b0;
    logic [8:0]   LNG_DATA = '0;
    logic         LNG_SRC_RDY = 1'b0;
    logic         LNG_DST_RDY;
    logic [255:0] TX_DATA;
    logic [1:0]   TX_SOF_POS;
    logic [4:0]   TX_EOF_POS;
    logic         TX_SOF, TX_EOF, TX_SRC_RDY;
    logic         TX_DST_RDY = 1'b1;

    mfb_frame_lng_gen dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .LNG_DATA(LNG_DATA), .LNG_SRC_RDY(LNG_SRC_RDY), .LNG_DST_RDY(LNG_DST_RDY),
        .TX_DATA(TX_DATA), .TX_SOF_POS(TX_SOF_POS), .TX_EOF_POS(TX_EOF_POS),
        .TX_SOF(TX_SOF), .TX_EOF(TX_EOF), .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
    );

    always #5 CLK = ~CLK;

    // One expected word: items [0,n1) = v1+k, items [s2,e2) = v2+(k-s2), rest 0.
    typedef struct {
        int cs; bit sof; int sof_pos; bit eof; int eof_pos;
        int n1; int v1; int s2; int e2; int v2;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   case_len [5][2] = '{'{60, 0}, '{40, 30}, '{20, 5}, '{0, 511}, '{10, 0}};
    int   case_cnt [5]    = '{1, 2, 2, 2, 1};

    int checks = 0;
    int errors = 0;
    int mode = 0;
    int extra_words = 0;

    int   len_q[$];
    bit   m_open;
    int   m_seq, m_val, m_cnt, m_frames;
    bit   p_stall;
    logic [299:0] p_bundle;
    logic [255:0] ew;
    int   fc, s, e;
    bit   closed;
    vec_t v;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [255:0] build_exp(input vec_t x);
        logic [255:0] r = '0;
        for (int k = 0; k < W; k++) begin
            if (k < x.n1) r[k*IW +: IW] = 8'(x.v1 + k);
            else if (k >= x.s2 && k < x.e2) r[k*IW +: IW] = 8'(x.v2 + k - x.s2);
        end
        return r;
    endfunction

    task automatic meter_close();
        int expl = -1;
        if (len_q.size() != 0) expl = len_q.pop_front();
        check("meter_len", 300'(m_cnt), 300'(expl));
        $display("frame %0d measured len %0d expected %0d", m_frames, m_cnt, expl);
        m_frames++;
        m_open = 0;
    endtask

    initial begin
        forever begin
            @(posedge CLK); #1;
            if (mode == 2) TX_DST_RDY = ($urandom_range(0, 99) < 60);
            else TX_DST_RDY = 1'b1;
        end
    end

    always @(negedge CLK) begin
        if (mode != 2) begin
            m_open = 0; m_seq = 0; m_val = 0; m_cnt = 0; m_frames = 0;
            len_q.delete(); p_stall = 0;
        end
        if (mode == 0) extra_words = 0;
        if (RESET_N && mode == 1 && TX_SRC_RDY && TX_DST_RDY) begin
            if (exp_q.size() == 0) begin
                extra_words++;
            end else begin
                v = exp_q.pop_front();
                $display("case %0d word: sof %0d pos %0d eof %0d pos %0d", v.cs, TX_SOF, TX_SOF_POS, TX_EOF, TX_EOF_POS);
                check("word_ctrl",
                      300'({TX_SOF, TX_SOF ? TX_SOF_POS : 2'd0, TX_EOF, TX_EOF ? TX_EOF_POS : 5'd0}),
                      300'({v.sof, 2'(v.sof_pos), v.eof, 5'(v.eof_pos)}));
                check("word_data", 300'(TX_DATA), 300'(build_exp(v)));
            end
        end
        if (RESET_N && mode == 2) begin
            if (LNG_SRC_RDY && LNG_DST_RDY) len_q.push_back(int'(LNG_DATA));
            if (p_stall)
                check("stall_hold", 300'({TX_SRC_RDY, TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS, TX_DATA}), p_bundle);
            p_stall  = TX_SRC_RDY && !TX_DST_RDY;
            p_bundle = 300'({TX_SRC_RDY, TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS, TX_DATA});
            if (TX_SRC_RDY && TX_DST_RDY) begin
                ew = '0; closed = 0; fc = 0;
                if (m_open) begin
                    if (TX_EOF && (!TX_SOF || int'(TX_SOF_POS) * BS > int'(TX_EOF_POS))) begin
                        fc = int'(TX_EOF_POS) + 1;
                        closed = 1;
                    end else begin
                        fc = W;
                    end
                    for (int k = 0; k < fc; k++) ew[k*IW +: IW] = 8'(m_val + k);
                    m_val += fc;
                    m_cnt += fc;
                    if (closed) meter_close();
                end
                if (TX_SOF && !m_open) begin
                    s = int'(TX_SOF_POS) * BS;
                    e = (TX_EOF && !closed) ? int'(TX_EOF_POS) + 1 : W;
                    m_val = m_seq;
                    m_seq = (m_seq + 1) % 256;
                    for (int k = s; k < e; k++) ew[k*IW +: IW] = 8'(m_val + k - s);
                    m_cnt = e - s;
                    m_val += e - s;
                    if (TX_EOF && !closed) meter_close();
                    else m_open = 1;
                end
                check("word_payload", 300'(TX_DATA), 300'(ew));
            end
        end
    end

    task automatic do_reset();
        @(posedge CLK); #1;
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ctrl", 300'({TX_SRC_RDY, TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS, LNG_DST_RDY}), 300'(0));
        check("rst_data", 300'(TX_DATA), 300'(0));
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("rst_release_dst_rdy_low", 300'(LNG_DST_RDY), 300'(0));
        @(posedge CLK); #1;
        check("first_edge_dst_rdy_high", 300'(LNG_DST_RDY), 300'(1));
    endtask

    task automatic send_lng(input int l);
        int t = 0;
        LNG_DATA = 9'(l);
        LNG_SRC_RDY = 1'b1;
        @(negedge CLK);
        while (!LNG_DST_RDY && t < 2000) begin
            @(negedge CLK);
            t++;
        end
        if (!LNG_DST_RDY) check("lng_accept_timeout", 300'(LNG_DST_RDY), 300'(1));
        @(posedge CLK); #1;
    endtask

    task automatic wait_words();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge CLK);
            t++;
        end
        check("words_missing", 300'(exp_q.size()), 300'(0));
        repeat (8) @(negedge CLK);
        check("words_extra", 300'(extra_words), 300'(0));
    endtask

    initial begin
        int cnt;
        int t;
        vecs.push_back('{0, 1, 0, 0, 0,  0,  0, 0, 32, 0});
        vecs.push_back('{0, 0, 0, 1, 27, 28, 32, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 0,  0,  0, 0, 32, 0});
        vecs.push_back('{1, 1, 1, 1, 7,  8,  32, 8, 32, 1});
        vecs.push_back('{1, 0, 0, 1, 5,  6,  25, 0, 0, 0});
        vecs.push_back('{2, 1, 0, 1, 19, 0,  0, 0, 20, 0});
        vecs.push_back('{2, 1, 0, 1, 4,  0,  0, 0, 5, 1});
        vecs.push_back('{3, 1, 0, 0, 0,  0,  0, 0, 32, 0});
        for (int i = 1; i < 15; i++) vecs.push_back('{3, 0, 0, 0, 0, 32, 32 * i, 0, 0, 0});
        vecs.push_back('{3, 0, 0, 1, 30, 31, 480, 0, 0, 0});
        vecs.push_back('{4, 1, 0, 1, 9,  0,  0, 0, 10, 0});

        for (int c = 0; c < 4; c++) begin
            mode = 0;
            do_reset();
            exp_q.delete();
            foreach (vecs[i]) if (vecs[i].cs == c) exp_q.push_back(vecs[i]);
            @(negedge CLK);
            mode = 1;
            @(posedge CLK); #1;
            for (int j = 0; j < case_cnt[c]; j++) send_lng(case_len[c][j]);
            LNG_SRC_RDY = 1'b0;
            wait_words();
        end

        // Reset while the third word of a 200-item frame is on the output.
        mode = 0;
        do_reset();
        send_lng(200);
        LNG_SRC_RDY = 1'b0;
        cnt = 0;
        t = 0;
        while (cnt < 3 && t < 100) begin
            @(negedge CLK);
            t++;
            if (TX_SRC_RDY && TX_DST_RDY) cnt++;
        end
        check("mid_word3_first_item", 300'(TX_DATA[7:0]), 300'(64));
        RESET_N = 1'b0;
        #1;
        check("mid_rst_ctrl", 300'({TX_SRC_RDY, TX_SOF, TX_EOF, TX_SOF_POS, TX_EOF_POS, LNG_DST_RDY}), 300'(0));
        check("mid_rst_data", 300'(TX_DATA), 300'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        exp_q.delete();
        foreach (vecs[i]) if (vecs[i].cs == 4) exp_q.push_back(vecs[i]);
        mode = 1;
        @(posedge CLK); #1;
        send_lng(case_len[4][0]);
        LNG_SRC_RDY = 1'b0;
        wait_words();

        // Random back-pressure, lengths checked by the meter model.
        mode = 0;
        do_reset();
        @(negedge CLK);
        mode = 2;
        @(posedge CLK); #1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                LNG_SRC_RDY = 1'b0;
                @(posedge CLK); #1;
            end
            send_lng($urandom_range(1, 511));
        end
        LNG_SRC_RDY = 1'b0;
        t = 0;
        while (m_frames < 300 && t < 30000) begin
            @(negedge CLK);
            t++;
        end
        @(posedge CLK); #1;
        check("meter_frames", 300'(m_frames), 300'(300));
        check("meter_open", 300'(m_open), 300'(0));
        check("meter_lengths_left", 300'(len_q.size()), 300'(0));
        mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
